// File: rtl/count_monitor.sv
// count_monitor: watches an upstream 4-bit counter. Every change in its value
// is queued in a 4-deep FIFO. Each queued value is then sent out on tx as a
// UART-like frame: one start bit, four data bits LSB first, one stop bit.
module count_monitor #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_in,
  output logic       tx,
  output logic       busy,
  output logic [2:0] fifo_level,
  output logic       overflow,
  output logic [2:0] io_oeb
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);

  logic [3:0] prev_count;
  logic [3:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [1:0] state;
  logic [7:0] bit_cnt;
  logic [1:0] bit_idx;
  logic [3:0] shift_reg;

  logic push;
  logic pop;
  logic full;
  logic accept;

  // The pads are always driven as outputs.
  assign io_oeb = 3'b000;

  // Push on any change of count_in. Pop only from IDLE with data waiting.
  // A push into a full FIFO still succeeds when a pop frees a slot on the same edge.
  always_comb begin
    push   = (count_in != prev_count);
    pop    = (state == S_IDLE) && (fifo_level != 3'd0);
    full   = (fifo_level == 3'd4);
    accept = push && (!full || pop);
  end

  // Change detector, FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every register
    // here then updates from values sampled before the edge, whatever the statement order.
    if (reset) begin
      prev_count <= 4'd0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_level <= 3'd0;
      overflow   <= 1'b0;
    end else begin
      prev_count <= count_in;
      if (accept) wr_ptr <= wr_ptr + 2'd1;
      if (pop)    rd_ptr <= rd_ptr + 2'd1;
      if (push && full && !pop) overflow <= 1'b1;
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + 3'd1;
        2'b01:   fifo_level <= fifo_level - 3'd1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // FIFO storage. Writes are ignored while reset is held.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset. An entry is only read after it has been
    // written, because level and pointers are reset. Leaving it unreset keeps it plain RAM.
    if (!reset && accept) mem[wr_ptr] <= count_in;
  end

  // Serializer: every state lasts CLKS_PER_BIT cycles. tx and busy are
  // registered and take the value of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= 8'd0;
      bit_idx   <= 2'd0;
      shift_reg <= 4'd0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shift_reg <= mem[rd_ptr];
            state     <= S_START;
            bit_cnt   <= 8'd0;
            tx        <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_START: begin
          if (bit_cnt == BIT_LAST) begin
            state   <= S_DATA;
            bit_cnt <= 8'd0;
            bit_idx <= 2'd0;
            tx      <= shift_reg[0];
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        S_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= 8'd0;
            if (bit_idx == 2'd3) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 2'd1;
              shift_reg <= {1'b0, shift_reg[3:1]};
              tx        <= shift_reg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        default: begin  // S_STOP
          if (bit_cnt == BIT_LAST) begin
            state   <= S_IDLE;
            bit_cnt <= 8'd0;
            busy    <= 1'b0;
            tx      <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Testbench for count_monitor. The reference model keeps the FIFO as a queue
// and the frame being sent as (value, cycle offset). From these it derives the
// expected tx/busy/fifo_level/overflow after every rising edge.
module tb_count_monitor;

  localparam int CPB   = 4;
  localparam int FRAME = 6 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count_in;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [2:0] io_oeb;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int         m_q[$];
  int         m_pos;      // offset within the current frame, -1 when idle
  logic [3:0] m_cur;
  logic [3:0] m_prev;
  bit         m_ovf;

  count_monitor #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .tx(tx), .busy(busy),
    .fifo_level(fifo_level), .overflow(overflow), .io_oeb(io_oeb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level at a given offset within the frame.
  function automatic logic exp_tx();
    int slot;
    if (m_pos < 0) return 1'b1;
    slot = m_pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 5) return 1'b1;
    return m_cur[slot-1];
  endfunction

  // Advance the model by one rising edge, using the inputs applied to that edge.
  task automatic model_edge(input logic r, input logic [3:0] c);
    bit do_pop;
    if (r) begin
      m_q.delete();
      m_pos  = -1;
      m_prev = 4'd0;
      m_ovf  = 1'b0;
      return;
    end
    do_pop = (m_pos < 0) && (m_q.size() != 0);
    if (m_pos >= 0) begin
      m_pos++;
      if (m_pos == FRAME) m_pos = -1;
    end
    if (do_pop) begin
      m_cur = 4'(m_q.pop_front());
      m_pos = 0;
    end
    if (c != m_prev) begin
      if (m_q.size() < 4) m_q.push_back(int'(c));
      else m_ovf = 1'b1;
    end
    m_prev = c;
  endtask

  // Apply inputs, take one rising edge, then compare all outputs on the falling edge.
  task automatic step(input logic r, input logic [3:0] c);
    reset    = r;
    count_in = c;
    @(posedge clk);
    model_edge(r, c);
    @(negedge clk);
    check("tx",         32'(tx),         32'(exp_tx()));
    check("busy",       32'(busy),       32'(m_pos >= 0));
    check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check("overflow",   32'(overflow),   32'(m_ovf));
  endtask

  task automatic hold(input int n, input logic [3:0] c);
    for (int i = 0; i < n; i++) step(1'b0, c);
  endtask

  initial begin
    int busy_cycles;
    int guard;
    logic [3:0] v;

    m_pos = -1; m_prev = 4'd0; m_ovf = 1'b0; m_cur = 4'd0;
    reset = 1'b1; count_in = 4'd0;
    @(negedge clk);

    // Reset, then quiet input for 10 cycles.
    step(1'b1, 4'd0);
    step(1'b1, 4'd0);
    check("io_oeb", 32'(io_oeb), 32'h0);
    hold(10, 4'd0);

    // A single change 0->5. Busy must be high for exactly one frame.
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 4'd5);
      if (busy) busy_cycles++;
    end
    check("busy_cycles", 32'(busy_cycles), 32'(FRAME));

    // Six changes on consecutive edges. The last one is dropped.
    step(1'b1, 4'd0);
    for (int i = 1; i <= 6; i++) step(1'b0, 4'(i));
    check("ovf_after_burst", 32'(overflow), 32'd1);
    hold(5 * (FRAME + 1) + 5, 4'd6);
    check("burst_drained", 32'(fifo_level), 32'd0);

    // Wrap 15 -> 0 gives two frames.
    step(1'b1, 4'd0);
    step(1'b0, 4'd15);
    step(1'b0, 4'd0);
    hold(2 * (FRAME + 1) + 4, 4'd0);

    // Reset during the DATA phase with two values queued.
    step(1'b1, 4'd0);
    step(1'b0, 4'd1); step(1'b0, 4'd2); step(1'b0, 4'd3);
    guard = 0;
    while (!(m_pos >= CPB && m_pos < 5 * CPB && m_q.size() >= 2) && guard < 50) begin
      step(1'b0, 4'd3);
      guard++;
    end
    check("reach_data", 32'(guard < 50), 32'd1);
    step(1'b1, 4'd3);
    check("abort_tx",    32'(tx),         32'd1);
    check("abort_busy",  32'(busy),       32'd0);
    check("abort_level", 32'(fifo_level), 32'd0);
    hold(3 * FRAME, 4'd0);

    // FIFO full while the serializer pops on the same edge a change arrives.
    step(1'b1, 4'd0);
    for (int i = 1; i <= 5; i++) step(1'b0, 4'(i));
    guard = 0;
    while (!(m_pos < 0 && m_q.size() == 4) && guard < 2 * FRAME) begin
      step(1'b0, 4'd5);
      guard++;
    end
    check("reach_full_idle", 32'(guard < 2 * FRAME), 32'd1);
    step(1'b0, 4'd9);
    check("full_pop_level", 32'(fifo_level), 32'd4);
    check("full_pop_ovf",   32'(overflow),   32'd0);
    hold(5 * (FRAME + 1), 4'd9);

    // Randomized traffic with occasional resets.
    v = 4'd0;
    step(1'b1, 4'd0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) v = 4'($urandom_range(0, 15));
      step($urandom_range(0, 499) == 0, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
